// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Checksum trailer support is selected with the LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, CNT, LOAD, WRITE, CSUM, DONE, ERR} state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_BYTES  = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: lane counter plus shift-in register.
// word/word_valid are combinational so the loader can register the write in the same edge.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (take) begin
            lane <= lane + 2'd1;
        end
    end

    // Only the first three bytes need storage; the fourth arrives on s_byte.
    always_ff @(posedge clk) begin
        if (take) begin
            shreg <= {byte_in, shreg[23:8]};
        end
    end

    assign word_valid = take && (lane == 2'(WORD_BYTES - 1));
    assign word       = {byte_in, shreg};

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> 32-bit instruction memory writes, CPU held until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 128,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_byte,
    output logic                  s_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [15:0] MAX_WORDS = 16'(DEPTH / WORD_BYTES);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif
    localparam logic END_DONE = (END_STATE == DONE);

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic        cnt_sel;
    logic        cnt_vld_p0;
    logic        accept;
    logic        session_start;
    logic        pack_take;
    logic        word_valid;
    logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept        = s_valid && s_ready;
    assign session_start = start && (state == IDLE || state == DONE || state == ERR);
    assign pack_take     = accept && (state == LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (session_start),
        .take       (pack_take),
        .byte_in    (s_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= BASE_ADDR;
            im_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
            cnt_sel    <= 1'b0;
            cnt_vld_p0 <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= CNT;
                        s_ready    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_hold   <= 1'b1;
                        cnt_sel    <= 1'b0;
                        cnt_vld_p0 <= 1'b0;
                        word_idx   <= '0;
                        im_addr    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                // --- p0: count captured; range check happens one cycle later
                CNT: begin
                    if (cnt_vld_p0) begin
                        cnt_vld_p0 <= 1'b0;
                        if (n_words == '0) begin
                            state    <= END_STATE;
                            s_ready  <= !END_DONE;
                            done     <= END_DONE;
                            cpu_hold <= !END_DONE;
                        end else if (n_words > MAX_WORDS) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end else if (accept) begin
                        if (cnt_sel != 1'(CNT_BYTES - 1)) begin
                            n_words[7:0] <= s_byte;
                            cnt_sel      <= 1'b1;
                        end else begin
                            n_words[15:8] <= s_byte;
                            s_ready       <= 1'b0;
                            cnt_vld_p0    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum + s_byte;
`endif
                        if (word_valid) begin
                            state   <= WRITE;
                            s_ready <= 1'b0;
                            im_we   <= 1'b1;
                            im_data <= DATA_WIDTH'(word);
                        end
                    end
                end
                // --- write cycle: im_we high exactly here, address advances afterwards
                WRITE: begin
                    im_addr  <= im_addr + ADDR_WIDTH'(WORD_BYTES);
                    word_idx <= word_idx + 16'd1;
                    if (word_idx == n_words - 16'd1) begin
                        state    <= END_STATE;
                        s_ready  <= !END_DONE;
                        done     <= END_DONE;
                        cpu_hold <= !END_DONE;
                    end else begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        s_ready <= 1'b0;
                        if (s_byte == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_byte = 8'h00;
    logic        s_ready, im_we, cpu_hold, done, err;
    logic [31:0] im_addr, im_data;

    int checks = 0;
    int errors = 0;
    int hold_viol = 0;
    int ready_viol = 0;

    logic [31:0]  wr_addr_q[$];
    logic [31:0]  wr_data_q[$];
    logic [31:0]  mem [32];
    byte unsigned pay_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [31:0]  exp_data_q[$];
    bit           exp_err;
    logic [7:0]   csum_byte;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_byte   (s_byte),
        .s_ready  (s_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    // Memory model and write log, sampled mid-cycle
    always @(negedge clk) begin
        if (rst && im_we) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_data);
            mem[im_addr[6:2]] = im_data;
            if (!cpu_hold) hold_viol++;
            if (s_ready) ready_viol++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit rnd_start, output bit ok);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_byte  = b;
        if (rnd_start) start = 1'($urandom_range(0, 1));
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (rnd_start) start = 1'($urandom_range(0, 1));
        end
        if (s_ready !== 1'b1) begin
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        s_byte  = 8'($urandom);
    endtask

    task automatic fill_payload(input int n);
        pay_q.delete();
        if (n <= 32) for (int i = 0; i < 4 * n; i++) pay_q.push_back(8'($urandom));
    endtask

    // Reference model: stream rules -> expected writes, outcome, checksum
    task automatic build_expected(input int n);
        logic [7:0] s;
        s = 8'h00;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_err = (n > 32);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(32'(4 * i));
                exp_data_q.push_back({pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
            end
        end
        foreach (pay_q[k]) s = s + pay_q[k];
        csum_byte = s;
    endtask

    task automatic drive_session(input int n, input bit rnd_start, output bit ok);
        bit b_ok;
        int w;
        logic [15:0] cnt;
        cnt = 16'(n);
        ok = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(cnt[7:0], 1'b1, rnd_start, b_ok);
        ok &= b_ok;
        send_byte(cnt[15:8], 1'b1, rnd_start, b_ok);
        ok &= b_ok;
        if (n <= 32) begin
            foreach (pay_q[k]) begin
                send_byte(pay_q[k], 1'b1, rnd_start, b_ok);
                ok &= b_ok;
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(csum_byte, 1'b1, rnd_start, b_ok);
            ok &= b_ok;
`endif
        end
        w = 0;
        while (!(done || err) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!(done || err)) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %0b want 1", cpu_hold); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready); end
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got %0b want 0", im_we); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %0b%0b want 00", done, err); end
        checks++; if (im_addr !== 32'h0 || im_data !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", im_addr, im_data); end
        start = 1'b0;
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready got %0b want 0", s_ready); end
    endtask

    task automatic test_directed_load();
        logic [7:0]  pl [8];
        logic [31:0] wexp [2];
        bit ok;
        int w;
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wexp = '{32'h0000_0013, 32'h0010_0093};
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        for (int wd = 0; wd < 2; wd++) begin
            for (int b = 0; b < 4; b++) send_byte(pl[4*wd+b], 1'b1, 1'b0, ok);
            @(negedge clk);
            checks++; if (im_we !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL load_pulse%0d we/ready got %0b/%0b want 1/0", wd, im_we, s_ready); end
            checks++; if (im_addr !== 32'(4 * wd)) begin errors++; $display("FAIL load_addr%0d got %h want %h", wd, im_addr, 32'(4 * wd)); end
            checks++; if (im_data !== wexp[wd]) begin errors++; $display("FAIL load_data%0d got %h want %h", wd, im_data, wexp[wd]); end
            @(negedge clk);
            checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL load_pulse_len%0d got %0b want 0", wd, im_we); end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB6, 1'b0, 1'b0, ok);
`endif
        w = 0;
        while (!done && w < 20) begin @(negedge clk); w++; end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL load_end done/hold/err got %0b/%0b/%0b want 1/0/0", done, cpu_hold, err); end
        checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL load_write_count got %0d want 2", wr_addr_q.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        int w;
        wr_addr_q.delete();
        pulse_start();
        send_byte(8'h21, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        w = 0;
        while (!err && w < 20) begin @(negedge clk); w++; end
        checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovf_err got err=%0b done=%0b want 1/0", err, done); end
        checks++; if (cpu_hold !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL ovf_hold_ready got %0b/%0b want 1/0", cpu_hold, s_ready); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL ovf_writes got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_zero_count();
        bit ok;
        wr_addr_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
`ifndef LOADER_CHECKSUM_EN
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_early_done got %0b want 0", done); end
        @(negedge clk);
`else
        send_byte(8'h00, 1'b0, 1'b0, ok);
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_done got done=%0b hold=%0b want 1/0", done, cpu_hold); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_reset_mid_session();
        bit ok;
        logic [31:0] w0;
        fill_payload(2);
        build_expected(2);
        w0 = exp_data_q[0];
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h02, 1'b1, 1'b0, ok);
        send_byte(8'h00, 1'b1, 1'b0, ok);
        for (int k = 0; k < 6; k++) send_byte(pay_q[k], 1'b1, 1'b0, ok);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b0 || im_we !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got ready/we/hold %0b/%0b/%0b want 0/0/1", s_ready, im_we, cpu_hold); end
        checks++; if (im_addr !== 32'h0 || im_data !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_regs got %h/%h/%0b/%0b want 0/0/0/0", im_addr, im_data, done, err); end
        checks++; if (wr_addr_q.size() != 1 || mem[0] !== w0) begin errors++; $display("FAIL mid_rst_word0 got n=%0d mem0=%h want 1/%h", wr_addr_q.size(), mem[0], w0); end
        rst = 1'b1;
        @(negedge clk);
        fill_payload(2);
        build_expected(2);
        drive_session(2, 1'b0, ok);
        checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL reload_done got ok=%0b done=%0b want 1/1", ok, done); end
        checks++; if (mem[0] !== exp_data_q[0] || mem[1] !== exp_data_q[1]) begin errors++; $display("FAIL reload_mem got %h %h want %h %h", mem[0], mem[1], exp_data_q[0], exp_data_q[1]); end
    endtask

    task automatic test_random_sessions();
        bit ok;
        int n;
        int r;
        for (int it = 0; it < 12; it++) begin
            if (it == 0) n = 32;
            else if (it == 1) n = 33;
            else begin
                r = $urandom_range(0, 9);
                if (r == 0) n = 0;
                else if (r == 1) n = 33 + $urandom_range(0, 300);
                else n = $urandom_range(1, 32);
            end
            fill_payload(n);
            build_expected(n);
            drive_session(n, 1'b1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_handshake n=%0d session stalled", it, n); end
            checks++; if (err !== exp_err || done !== !exp_err) begin errors++; $display("FAIL rnd%0d_outcome n=%0d got done=%0b err=%0b want err=%0b", it, n, done, err, exp_err); end
            checks++; if (cpu_hold !== exp_err) begin errors++; $display("FAIL rnd%0d_hold got %0b want %0b", it, cpu_hold, exp_err); end
            checks++; if (wr_addr_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, wr_addr_q.size(), exp_addr_q.size()); end
            foreach (exp_addr_q[i]) begin
                if (i < wr_addr_q.size()) begin
                    checks++;
                    if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_word%0d got %h:%h want %h:%h", it, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                    end
                end
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_expected(2);
        checks++; if (csum_byte !== 8'hB6) begin errors++; $display("FAIL csum_model got %h want b6", csum_byte); end
        drive_session(2, 1'b0, ok);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL csum_good got done=%0b err=%0b want 1/0", done, err); end
        csum_byte = 8'hB7;
        drive_session(2, 1'b0, ok);
        checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL csum_bad got err=%0b done=%0b hold=%0b want 1/0/1", err, done, cpu_hold); end
        checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL csum_bad_writes got %0d want 2", wr_addr_q.size()); end
    endtask
`endif

    task automatic test_invariants();
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL we_without_hold got %0d want 0", hold_viol); end
        checks++; if (ready_viol != 0) begin errors++; $display("FAIL ready_during_write got %0d want 0", ready_viol); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        test_reset();
        test_directed_load();
        test_overflow();
        test_zero_count();
        test_reset_mid_session();
        test_random_sessions();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
